// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Programmable clock divider / clock-enable generator. It produces a registered
// near-50%-duty divided level and a one-cycle tick at the start of every
// period. The divisor can be reloaded at runtime. A new value takes effect only
// at a period boundary, so no runt or stretched periods are produced.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   en       in   count enable; when low, count and level freeze and tick is 0
//   restart  in   synchronous restart of the current period (wins over en)
//   div_in   in   new divisor value (0 and 1 are treated as 2)
//   div_load in   one-cycle strobe that captures div_in
//   div_out  out  divided level, registered
//   tick     out  one-cycle pulse at the start of each period, registered
//   cur_div  out  divisor currently in effect (clamped), registered
// -----------------------------------------------------------------------------
module clk_div_prog #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             restart,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_out,
   output logic             tick,
   output logic [CNT_W-1:0] cur_div
);

   localparam logic [CNT_W-1:0] L_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_TWO     = CNT_W'(2);
   localparam logic [CNT_W-1:0] L_DEF_DIV = (DEFAULT_DIV < 2) ? L_TWO : CNT_W'(DEFAULT_DIV);

   // Any divisor below 2 is treated as 2.
   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
      return (v < L_TWO) ? L_TWO : v;
   endfunction

   // ceil(d/2). The extra bit keeps d = all-ones from overflowing.
   function automatic logic [CNT_W-1:0] high_cycles(input logic [CNT_W-1:0] d);
      logic [CNT_W:0] w_sum;
      w_sum = {1'b0, d} + {{CNT_W{1'b0}}, 1'b1};
      return w_sum[CNT_W:1];
   endfunction

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_pend_div;
   logic             r_pend_vld;
   logic             r_div_out;
   logic             r_tick;

   logic [CNT_W-1:0] w_din_clamped;
   logic             w_new_avail;
   logic [CNT_W-1:0] w_new_div;
   logic             w_wrap;
   logic [CNT_W-1:0] w_next_cnt;
   logic             w_next_high;

   assign w_din_clamped = clamp_div(div_in);
   // A strobe in the same cycle overrides an older pending value.
   assign w_new_avail   = div_load | r_pend_vld;
   assign w_new_div     = div_load ? w_din_clamped : r_pend_div;
   assign w_wrap        = (r_cnt == (r_div - L_ONE));
   assign w_next_cnt    = w_wrap ? L_ZERO : (r_cnt + L_ONE);
   // Only used on non-wrap edges. At a wrap next_cnt is 0 and H >= 1,
   // so the level is always high there whatever the new divisor is.
   assign w_next_high   = (w_next_cnt < high_cycles(r_div));

   // Counter, divisor hand-over and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= L_DEF_DIV - L_ONE;
         r_div      <= L_DEF_DIV;
         r_pend_div <= L_DEF_DIV;
         r_pend_vld <= 1'b0;
         r_div_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else if (restart) begin
         r_cnt      <= L_ZERO;
         r_div_out  <= 1'b1;
         r_tick     <= 1'b1;
         r_pend_vld <= 1'b0;
         if (w_new_avail) begin
            r_div <= w_new_div;
         end
      end else if (en) begin
         r_cnt  <= w_next_cnt;
         r_tick <= w_wrap;
         if (w_wrap) begin
            r_div_out  <= 1'b1;
            r_pend_vld <= 1'b0;
            if (w_new_avail) begin
               r_div <= w_new_div;
            end
         end else begin
            r_div_out <= w_next_high;
            if (div_load) begin
               r_pend_div <= w_din_clamped;
               r_pend_vld <= 1'b1;
            end
         end
      end else begin
         // Frozen. Loads are still captured for the next wrap.
         r_tick <= 1'b0;
         if (div_load) begin
            r_pend_div <= w_din_clamped;
            r_pend_vld <= 1'b1;
         end
      end
   end

   assign div_out = r_div_out;
   assign tick    = r_tick;
   assign cur_div = r_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Directed, table-driven bench for clk_div_prog with DEFAULT_DIV = 4.
// Each table row gives the inputs for one clock edge and the expected
// div_out, tick and cur_div after that edge. A hand-written sequence then
// covers asynchronous reset with a load pending, and restart.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

   logic        clk;
   logic        reset;
   logic        en;
   logic        restart;
   logic [15:0] div_in;
   logic        div_load;
   logic        div_out;
   logic        tick;
   logic [15:0] cur_div;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        en;
      logic        restart;
      logic        ld;
      logic [15:0] din;
      logic        exp_out;
      logic        exp_tick;
      logic [15:0] exp_cur;
   } vec_t;

   vec_t vecs[$];

   clk_div_prog #(.CNT_W(16), .DEFAULT_DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .restart  (restart),
      .div_in   (div_in),
      .div_load (div_load),
      .div_out  (div_out),
      .tick     (tick),
      .cur_div  (cur_div)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic e, input logic rs, input logic ld, input logic [15:0] din,
                      input logic o, input logic t, input logic [15:0] c);
      vec_t v;
      v.en = e; v.restart = rs; v.ld = ld; v.din = din;
      v.exp_out = o; v.exp_tick = t; v.exp_cur = c;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic o, input logic t, input logic [15:0] c);
      check({tag, " div_out"}, {15'd0, div_out}, {15'd0, o});
      check({tag, " tick"},    {15'd0, tick},    {15'd0, t});
      check({tag, " cur_div"}, cur_div, c);
   endtask

   // Drive one edge's inputs, clock, then sample 1 time unit after the edge.
   task automatic step(input string tag, input logic e, input logic rs, input logic ld,
                       input logic [15:0] din, input logic o, input logic t, input logic [15:0] c);
      en = e; restart = rs; div_load = ld; div_in = din;
      @(posedge clk);
      #1;
      check_all(tag, o, t, c);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; restart = 1'b0; div_load = 1'b0; div_in = 16'd0;

      // Plain D=4 run: edges 1..12
      for (int p = 0; p < 3; p++) begin
         add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd4);
         add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd4);
         add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd4);
         add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd4);
      end
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd4);   // 13 wrap
      // Load 5 mid-period: current period keeps 4 cycles
      add(1'b1, 1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 16'd4);   // 14
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd4);   // 15
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd4);   // 16
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd5);   // 17 wrap, D=5
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd5);   // 18
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd5);   // 19
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd5);   // 20
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd5);   // 21
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd5);   // 22 wrap
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd5);   // 23
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd5);   // 24
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd5);   // 25
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd5);   // 26
      // Load 8 on the wrap edge itself: applied immediately
      add(1'b1, 1'b0, 1'b1, 16'd8, 1'b1, 1'b1, 16'd8);   // 27
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd8);   // 28
      add(1'b1, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0, 16'd8);   // 29 load 3 (cnt was 1)
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd8);   // 30
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd8);   // 31
      add(1'b1, 1'b0, 1'b1, 16'd6, 1'b0, 1'b0, 16'd8);   // 32 load 6 (cnt was 4)
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd8);   // 33
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd8);   // 34
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd6);   // 35 wrap, last load wins
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);   // 36
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);   // 37
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd6);   // 38
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd6);   // 39
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd6);   // 40
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd6);   // 41 wrap
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);   // 42
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);   // 43 cnt=2
      // en low for 3 edges; load 0 captured while frozen
      add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);   // 44
      add(1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 16'd6);   // 45
      add(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);   // 46
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd6);   // 47 cnt=3
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd6);   // 48
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd6);   // 49
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd2);   // 50 wrap, clamp(0)=2
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd2);   // 51
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd2);   // 52
      add(1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 16'd2);   // 53 load 1 -> 2
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd2);   // 54
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd2);   // 55
      add(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd2);   // 56

      // Reset state, held across a couple of edges
      #22;
      check_all("reset_hold", 1'b0, 1'b0, 16'd4);

      @(negedge clk);
      reset = 1'b0;
      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i + 1), vecs[i].en, vecs[i].restart, vecs[i].ld,
              vecs[i].din, vecs[i].exp_out, vecs[i].exp_tick, vecs[i].exp_cur);
      end

      // Load 7 while frozen, then asynchronous reset between edges
      step("pend7", 1'b0, 1'b0, 1'b1, 16'd7, 1'b1, 1'b0, 16'd2);
      div_load = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check_all("async_rst", 1'b0, 1'b0, 16'd4);
      @(negedge clk);
      reset = 1'b0;

      // Pending 7 must be gone: plain D=4 periods
      step("rel1", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd4);
      step("rel2", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd4);
      step("rel3", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd4);
      step("rel4", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd4);
      step("rel5", 1'b1, 1'b0, 1'b1, 16'd6, 1'b1, 1'b1, 16'd6);
      step("rel6", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);
      step("rel7", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);
      step("rel8", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd6);
      // Restart at cnt=3
      step("rst_c3", 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 16'd6);
      step("after_rs", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd6);
      // Restart with a simultaneous load applies it now
      step("rs_load", 1'b1, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 16'd3);
      step("d3_c1", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd3);
      step("d3_c2", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd3);
      step("d3_wrap", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd3);
      // Restart wins over en=0
      step("rs_en0", 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 16'd3);
      step("rs_en0_n", 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
